// File: rtl/mul_ctrl.sv
// Sequencing controller for the EX-stage multiplier: takes signed/unsigned
// operands, feeds magnitudes to an unsigned multiplier, and sign-corrects the product.
module mul_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [4:0]         req_rd,
  input  logic               flush,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_data,
  output logic [4:0]         resp_rd,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [1:0]         OP_MUL   = 2'b00;
  localparam logic [1:0]         OP_MULH  = 2'b01;
  localparam logic [1:0]         OP_MULHSU = 2'b10;
  localparam logic [3:0]         CNT_INIT = 4'(LATENCY - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [1:0]         op_q, op_d;
  logic [4:0]         rd_q, rd_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic               resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]   resp_data_q, resp_data_d;
  logic [4:0]         resp_rd_q, resp_rd_d;

  logic               a_neg, b_neg;
  logic [2*WIDTH-1:0] prod_fix;

  // Only the high-half signed variants treat operands as signed; MUL's low half is sign-agnostic.
  assign a_neg    = ((req_op == OP_MULH) || (req_op == OP_MULHSU)) && req_a[WIDTH-1];
  assign b_neg    = (req_op == OP_MULH) && req_b[WIDTH-1];
  assign prod_fix = neg_q ? (~mul_result + ONE_2W) : mul_result;

  assign req_ready  = (state_q == IDLE) && !flush;
  assign busy       = (state_q != IDLE);
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    neg_d        = neg_q;
    op_d         = op_q;
    rd_d         = rd_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          rd_d    = req_rd;
          neg_d   = a_neg ^ b_neg;
          mul_a_d = a_neg ? (~req_a + ONE_W) : req_a;
          mul_b_d = b_neg ? (~req_b + ONE_W) : req_b;
          cnt_d   = CNT_INIT;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == 4'd0) begin
          resp_data_d  = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
          resp_rd_d    = rd_q;
          resp_valid_d = 1'b1;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase

    // Flush overrides everything, including a completing writeback handshake.
    if (flush) begin
      state_d      = IDLE;
      resp_valid_d = 1'b0;
      cnt_d        = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      neg_q        <= 1'b0;
      op_q         <= 2'b00;
      rd_q         <= 5'd0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= 5'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      neg_q        <= neg_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
    end
  end

endmodule
